// File: rtl/mmio_gpio_bank_if.sv
// Data-bus side of the GPIO bank: address/write strobe/data from the core,
// address-hit and combinational read data back to the core's read mux.
interface mmio_gpio_bank_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input sel, input rdata);
    modport slave  (input addr, input we, input wdata, output sel, output rdata);
endinterface

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: NCH channels of WIDTH bits, each with an output
// latch, direction register, two-flop input synchroniser and sticky
// rising-edge flags (write-1-to-clear), plus a registered interrupt line.
// Reads are combinational so the single-cycle core sees data in the same cycle.
module mmio_gpio_bank #(
    parameter int          WIDTH     = 8,
    parameter int          NCH       = 4,
    parameter logic [31:0] BASE_ADDR = 32'h800
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_gpio_bank_if.slave      bus,
    input  logic [NCH*WIDTH-1:0] i_pin_in,
    output logic [NCH*WIDTH-1:0] o_pin_out,
    output logic [NCH*WIDTH-1:0] o_pin_oe,
    output logic                 o_irq
);
    localparam int          NW      = NCH * WIDTH;
    // Channel registers plus the single IRQEN word that follows them.
    localparam logic [31:0] LP_SPAN = 32'(16 * NCH + 4);

    logic [31:0]    w_off;
    logic           w_sel;
    logic [3:0]     w_ch;
    logic [1:0]     w_reg;
    logic           w_wr;
    logic           w_wr_irqen;
    logic [NCH-1:0] w_wr_dout;
    logic [NCH-1:0] w_wr_dir;
    logic [NCH-1:0] w_wr_edge;
    logic [NCH-1:0] w_any_edge;
    logic [NW-1:0]  w_clr;
    logic [NW-1:0]  w_rise;
    logic [31:0]    w_rdata;
    logic           w_unused;

    logic [NW-1:0]  r_dout;
    logic [NW-1:0]  r_dir;
    logic [NW-1:0]  r_edge;
    logic [NW-1:0]  r_s1;
    logic [NW-1:0]  r_s2;
    logic [NW-1:0]  r_prev;
    logic [NCH-1:0] r_irqen;
    logic           r_irq;

    // Address decode: word-aligned hits inside the bank only.
    assign w_off      = bus.addr - BASE_ADDR;
    assign w_sel      = (bus.addr >= BASE_ADDR) && (w_off < LP_SPAN) && (bus.addr[1:0] == 2'b00);
    assign w_ch       = w_off[7:4];
    assign w_reg      = w_off[3:2];
    assign w_wr       = bus.we & w_sel;
    assign w_wr_irqen = w_wr && (w_ch == 4'(NCH));
    assign w_rise     = r_s2 & ~r_prev;

    // Bits of the offset and store data that the map never looks at.
    assign w_unused = &{1'b0, w_off[31:8], w_off[1:0], bus.wdata};

    // Per-channel write strobes, W1C masks and flag summaries.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign w_wr_dout[gi]  = w_wr && (w_ch == 4'(gi)) && (w_reg == 2'd0);
            assign w_wr_dir[gi]   = w_wr && (w_ch == 4'(gi)) && (w_reg == 2'd2);
            assign w_wr_edge[gi]  = w_wr && (w_ch == 4'(gi)) && (w_reg == 2'd3);
            assign w_clr[gi*WIDTH +: WIDTH] = w_wr_edge[gi] ? bus.wdata[WIDTH-1:0] : '0;
            assign w_any_edge[gi] = |r_edge[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Input synchroniser and previous-sample flop feeding the edge detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= i_pin_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // Sticky edge flags (set beats clear) and the registered interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_rise;
            r_irq  <= |(r_irqen & w_any_edge);
        end
    end

    // Software-writable registers: DOUT, DIR per channel and global IRQEN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout  <= '0;
            r_dir   <= '0;
            r_irqen <= '0;
        end else begin
            if (w_wr_irqen) begin
                r_irqen <= bus.wdata[NCH-1:0];
            end
            for (int c = 0; c < NCH; c++) begin
                if (w_wr_dout[c]) begin
                    r_dout[c*WIDTH +: WIDTH] <= bus.wdata[WIDTH-1:0];
                end
                if (w_wr_dir[c]) begin
                    r_dir[c*WIDTH +: WIDTH] <= bus.wdata[WIDTH-1:0];
                end
            end
        end
    end

    // Combinational, side-effect-free read mux; zero outside the bank.
    always_comb begin
        w_rdata = '0;
        if (w_sel) begin
            if (w_ch == 4'(NCH)) begin
                w_rdata[NCH-1:0] = r_irqen;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (w_ch == 4'(c)) begin
                        case (w_reg)
                            2'd0:    w_rdata[WIDTH-1:0] = r_dout[c*WIDTH +: WIDTH];
                            2'd1:    w_rdata[WIDTH-1:0] = r_s2[c*WIDTH +: WIDTH];
                            2'd2:    w_rdata[WIDTH-1:0] = r_dir[c*WIDTH +: WIDTH];
                            default: w_rdata[WIDTH-1:0] = r_edge[c*WIDTH +: WIDTH];
                        endcase
                    end
                end
            end
        end
    end

    assign bus.sel   = w_sel;
    assign bus.rdata = w_rdata;
    assign o_pin_out = r_dout;
    assign o_pin_oe  = r_dir;
    assign o_irq     = r_irq;

endmodule

// File: doc/mmio_gpio_bank.md
Name: mmio_gpio_bank

Overview:
- Parametrised memory-mapped GPIO block that succeeds the single 8-bit in/out port pair on the ARM single-cycle core's data bus.
- Provides NCH independent channels of WIDTH bits, each with:
  - an output latch and a per-bit direction register
  - a two-flop input synchroniser
  - sticky rising-edge flags with write-1-to-clear
- Produces one registered interrupt line.
- Sits beside dmem. The top-level read mux selects rdata whenever sel is high.

Parameters:
- WIDTH, 8, bits per channel; legal range 1..32.
- NCH, 4, number of channels; legal range 1..8.
- BASE_ADDR, 32'h800, byte address of channel 0 register 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  byte address from ALUResult.
- we  input  1  MemWrite from the core.
- wdata  input  32  store data; only bits [WIDTH-1:0] are used.
- sel  output  1  combinational address hit; drives the top-level read mux.
- rdata  output  32  combinational read data, zero-extended; 0 when sel=0.
- pin_in  input  NCH*WIDTH  asynchronous external inputs; channel c occupies bits [c*WIDTH +: WIDTH].
- pin_out  output  NCH*WIDTH  output latch contents.
- pin_oe  output  NCH*WIDTH  per-bit output enable (=DIR).
- irq  output  1  registered interrupt request.

Behaviour:
- Register map. Channel c base is BASE_ADDR + 16*c:
  - +0 DOUT: R/W.
  - +4 DIN: RO; returns synchroniser stage 2 for all bits, regardless of DIR.
  - +8 DIR: R/W; 1 = output.
  - +12 EDGE: R, W1C.
- Global register IRQEN at BASE_ADDR + 16*NCH: R/W, NCH bits, bit c enables channel c.
- sel = 1 iff BASE_ADDR <= addr < BASE_ADDR + 16*NCH + 4 and addr[1:0] == 0. Misaligned addresses give sel=0, so no write happens and rdata=0.
- Reads are purely combinational, with zero latency to match the single-cycle core. Reads have no side effects; in particular, reading EDGE does not clear it.
- Writes take effect at the posedge where we & sel. Writes to DIN are ignored. wdata bits above WIDTH (or above NCH for IRQEN) are ignored.
- Input path for each bit:
  - s1 <= pin_in; s2 <= s1; prev <= s2.
  - rise = s2 & ~prev.
  - EDGE <= (EDGE & ~clr) | rise, where clr = wdata[WIDTH-1:0] when EDGE is written, otherwise 0.
  - If set and clear hit the same bit in the same cycle, set wins.
- Latency for a pin that rises before edge k:
  - s1 = 1 after edge k.
  - DIN reads 1 after edge k+1.
  - EDGE bit = 1 after edge k+2.
  - irq = 1 after edge k+3, provided IRQEN is set.
- Falling edges and steady levels never set EDGE.
- irq <= OR over c of (IRQEN[c] & |EDGE[c]). irq is a flop, so it drops one cycle after the last contributing flag is cleared or disabled.
- pin_out = DOUT and pin_oe = DIR, both straight from registers with no extra latency.
- Reset (async, any time, including mid-write): DOUT, DIR, EDGE, IRQEN, s1, s2, prev and irq all go to 0. Because prev resets to 0, a pin that is high at reset release sets EDGE 3 edges after release. Software clears this with a W1C.
- No state changes when sel=0, apart from the synchroniser, prev, EDGE set and irq.

Test Plan (WIDTH=8, NCH=4, BASE_ADDR=0x800):
- Reset with pin_in all zero, then read 0x800–0x840 -> rdata=0 everywhere; pin_out=0, pin_oe=0, irq=0.
- Write 0x800=0x5A and 0x808=0xF0 -> next cycle pin_out[7:0]=0x5A, pin_oe[7:0]=0xF0; read 0x800 -> 0x0000005A; write 0x804=0xFF -> DIN unchanged.
- Write 0x840=0x2, then drive pin_in[15:8] from 0x00 to 0x81 before edge k -> 0x814 reads 0x81 after edge k+2; irq=1 after edge k+3; 0x810 unaffected by pin_in.
- With EDGE ch1=0x81, write 0x81C=0x01 -> EDGE=0x80 and irq stays 1; write 0x81C=0x80 -> EDGE=0, irq=0 one edge later; write 0x840=0 while a flag is set -> irq falls one edge later.
- Same-cycle W1C of bit0 while a new rise of bit0 arrives -> EDGE bit0 stays 1; reads of 0x801 and 0x844 give sel=0, rdata=0, and writes there change nothing.
- Assert reset asynchronously mid-cycle with DOUT=0xFF and EDGE=0x3 -> all outputs 0 immediately; a pin held high through release sets EDGE 3 edges later.
